alarm_controller: RTL

//   Downstream consumer of the mm:ss clock counter outputs (sec_binary/min_binary).

---
 rtl/alarm_controller_pkg.sv | 21 ++
 rtl/alarm_controller_mod60_updown.sv | 26 ++
 rtl/alarm_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: minute range, FSM state
// encoding and the mod-60 wrap helpers used by the alarm-minute register.
package alarm_controller_pkg;

   localparam int MIN_MAX = 59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } alarm_state_t;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v);
      return (v == 6'(MIN_MAX)) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] wrap_dec(input logic [5:0] v);
      return (v == 6'd0) ? 6'(MIN_MAX) : v - 6'd1;
   endfunction

endpackage

// File: rtl/alarm_controller_mod60_updown.sv
// 6-bit wrapping up/down register (0..59) holding the programmed alarm minute.
module mod60_updown
   import alarm_controller_pkg::*;
(
   input  logic       clk_1H,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [5:0] q
);

   logic [5:0] val_q;

   always_ff @(posedge clk_1H or posedge reset) begin
      if (reset) begin
         val_q <= 6'd0;
      end else if (inc) begin
         val_q <= wrap_inc(val_q);
      end else if (dec) begin
         val_q <= wrap_dec(val_q);
      end
   end

   assign q = val_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: fires at alarm_min:00, rings for a bounded time with a
// beeping buzzer, and allows a limited number of snoozes per alarm event.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | armed or disarmed, waiting for alarm_min:00
//   ST_RINGING | buzzer beeping, ring timer running
//   ST_SNOOZED | buzzer silent, snooze timer running toward re-ring
module alarm_controller
   import alarm_controller_pkg::*;
#(
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 120,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk_1H,
   input  logic       reset,
   input  logic [5:0] sec_binary,
   input  logic [5:0] min_binary,
   input  logic       alarm_set_switch,
   input  logic       incr_pb,
   input  logic       decr_pb,
   input  logic       alarm_enable,
   input  logic       snooze_pb,
   input  logic       stop_pb,
   output logic [5:0] alarm_min,
   output logic       buzzer,
   output logic       alarm_ringing,
   output logic       snooze_active,
   output logic [1:0] snooze_count
);

   localparam int RW = $clog2(RING_SECS);
   localparam int SW = $clog2(SNOOZE_SECS);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
   localparam logic [1:0]    SNZ_LIMIT = 2'(MAX_SNOOZE);

   alarm_state_t  state_q;
   logic [RW-1:0] ring_cnt_q;
   logic [SW-1:0] snz_cnt_q;
   logic [1:0]    snz_used_q;
   logic          buzzer_q;
   logic          ringing_q;
   logic          snoozing_q;

   logic set_inc;
   logic set_dec;
   logic trigger;

   // incr wins when both buttons are held
   assign set_inc = alarm_set_switch & incr_pb;
   assign set_dec = alarm_set_switch & decr_pb & ~incr_pb;

   mod60_updown u_alarm_min (
      .clk_1H (clk_1H),
      .reset  (reset),
      .inc    (set_inc),
      .dec    (set_dec),
      .q      (alarm_min)
   );

   assign trigger = alarm_enable && (state_q == ST_IDLE) &&
                    (min_binary == alarm_min) && (sec_binary == 6'd0);

   always_ff @(posedge clk_1H or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         snz_used_q <= 2'd0;
         buzzer_q   <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
      end else if (!alarm_enable) begin
         state_q    <= ST_IDLE;
         snz_used_q <= 2'd0;
         buzzer_q   <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trigger) begin
                  state_q    <= ST_RINGING;
                  ring_cnt_q <= '0;
                  snz_used_q <= 2'd0;
                  buzzer_q   <= 1'b1;
                  ringing_q  <= 1'b1;
               end
            end
            ST_RINGING: begin
               if (stop_pb) begin
                  state_q   <= ST_IDLE;
                  buzzer_q  <= 1'b0;
                  ringing_q <= 1'b0;
               end else if (snooze_pb && (snz_used_q < SNZ_LIMIT)) begin
                  state_q    <= ST_SNOOZED;
                  snz_cnt_q  <= '0;
                  snz_used_q <= snz_used_q + 2'd1;
                  buzzer_q   <= 1'b0;
                  ringing_q  <= 1'b0;
                  snoozing_q <= 1'b1;
               end else if (ring_cnt_q == RING_LAST) begin
                  state_q   <= ST_IDLE;
                  buzzer_q  <= 1'b0;
                  ringing_q <= 1'b0;
               end else begin
                  ring_cnt_q <= ring_cnt_q + RW'(1);
                  buzzer_q   <= ~buzzer_q;
               end
            end
            ST_SNOOZED: begin
               if (stop_pb) begin
                  state_q    <= ST_IDLE;
                  snoozing_q <= 1'b0;
               end else if (snz_cnt_q == SNZ_LAST) begin
                  state_q    <= ST_RINGING;
                  ring_cnt_q <= '0;
                  buzzer_q   <= 1'b1;
                  ringing_q  <= 1'b1;
                  snoozing_q <= 1'b0;
               end else begin
                  snz_cnt_q <= snz_cnt_q + SW'(1);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               buzzer_q   <= 1'b0;
               ringing_q  <= 1'b0;
               snoozing_q <= 1'b0;
            end
         endcase
      end
   end

   assign buzzer        = buzzer_q;
   assign alarm_ringing = ringing_q;
   assign snooze_active = snoozing_q;
   assign snooze_count  = snz_used_q;

endmodule
